// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg -- shared encodings for the multi-cycle MIPS core.
// Holds the control FSM state enum, opcode/funct values, ALU operation codes,
// PC / register-destination / write-back source select codes, the decoded
// instruction class and the packed control word driven by mc_ctrl_fsm.
// Also used by the ALU and datapath so that select encodings stay in one place.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_BRANCH,
    ST_HALT
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  localparam logic [1:0] PCSRC_PC4 = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;
  localparam logic [1:0] PCSRC_RS  = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU  = 2'd0;
  localparam logic [1:0] M2R_MEM  = 2'd1;
  localparam logic [1:0] M2R_PC4  = 2'd2;

  localparam int unsigned MEM_TIMEOUT_DEF = 255;

  // One-hot instruction class; exactly one bit is set for any op/funct.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
    logic ill;
  } instr_cls_t;

  // Full control word presented to the datapath.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       ext_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       trap;
  } ctl_t;

  function automatic logic cls_is_alu(instr_cls_t c);
    return c.addu | c.subu | c.ori | c.lui;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode -- combinational instruction classifier.
// Ports:
//   op_i    [5:0]  IR[31:26]
//   funct_i [5:0]  IR[5:0]
//   cls_o          one-hot instruction class (ill set for anything unsupported)
// Only op/funct are visible here, so an R-type with funct 0 (sll) is treated
// as the all-zero nop word.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output instr_cls_t cls_o
);

  always_comb begin
    cls_o = '0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: cls_o.addu = 1'b1;
          FN_SUBU: cls_o.subu = 1'b1;
          FN_JR:   cls_o.jr   = 1'b1;
          FN_SLL:  cls_o.nop  = 1'b1;
          default: cls_o.ill  = 1'b1;
        endcase
      end
      OP_J:    cls_o.j   = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      default: cls_o.ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multi-cycle control FSM for the MIPS core.
// Sequences FETCH/DECODE/EXEC/MEM/WB (plus BRANCH and HALT), waits on
// mem_ready for fetch/load/store and traps on illegal ops or memory timeout.
// Ports:
//   clk, reset (async, active low)
//   op, funct      instruction fields from IR (valid from DECODE on)
//   zero           ALU zero flag, used by beq
//   mem_ready      memory completion, only observed in FETCH/MEM
//   mem_req/mem_we memory strobe / store qualifier
//   ir_write, pc_write, pc_src, alu_op, alu_src, ext_op,
//   reg_write, reg_dst, mem_to_reg   datapath controls
//   trap           illegal instruction or memory timeout (sticky via HALT)
// Optional build macro MC_CTRL_PERF_EN adds cyc_cnt / instr_cnt outputs.
// Outputs are a combinational decode of state + inputs, forced to 0 while
// reset is asserted so a reset mid-access drops mem_req at once.
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic        alu_src,
  output logic        ext_op,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        trap
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [7:0] TO_LIM = MEM_TIMEOUT[7:0];

  state_e     state_q, state_d;
  logic [7:0] tmo_q, tmo_d;
  instr_cls_t cls;
  ctl_t       ctl, ctl_o;
  logic       waiting, timed_out;

  mc_ctrl_decode u_dec (
    .op_i    (op),
    .funct_i (funct),
    .cls_o   (cls)
  );

  assign waiting   = (state_q == ST_FETCH) || (state_q == ST_MEM);
  // ready on the limit cycle takes priority over the timeout
  assign timed_out = waiting && !mem_ready && (tmo_q == TO_LIM);

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    case (state_q)
      ST_FETCH: begin
        ctl.mem_req = 1'b1;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PCSRC_PC4;
          state_d      = ST_DECODE;
        end else if (timed_out) begin
          ctl.trap = 1'b1;
          state_d  = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (cls.ill) begin
          ctl.trap = 1'b1;
          state_d  = ST_HALT;
        end else if (cls_is_alu(cls) || cls.lw || cls.sw) begin
          state_d = ST_EXEC;
        end else if (cls.beq) begin
          state_d = ST_BRANCH;
        end else if (cls.j) begin
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PCSRC_JMP;
          state_d      = ST_FETCH;
        end else if (cls.jal) begin
          ctl.pc_write   = 1'b1;
          ctl.pc_src     = PCSRC_JMP;
          ctl.reg_write  = 1'b1;
          ctl.reg_dst    = REGDST_RA;
          ctl.mem_to_reg = M2R_PC4;
          state_d        = ST_FETCH;
        end else if (cls.jr) begin
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PCSRC_RS;
          state_d      = ST_FETCH;
        end else if (cls.nop) begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (cls.subu) begin
          ctl.alu_op = ALU_SUB;
        end else if (cls.ori) begin
          ctl.alu_op  = ALU_OR;
          ctl.alu_src = 1'b1;
        end else if (cls.lui) begin
          ctl.alu_op  = ALU_LUI;
          ctl.alu_src = 1'b1;
        end else if (cls.lw || cls.sw) begin
          ctl.alu_op  = ALU_ADD;
          ctl.alu_src = 1'b1;
          ctl.ext_op  = 1'b1;
        end
        state_d = (cls.lw || cls.sw) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        ctl.mem_req = 1'b1;
        ctl.mem_we  = cls.sw;
        if (mem_ready) begin
          state_d = cls.sw ? ST_FETCH : ST_WB;
        end else if (timed_out) begin
          ctl.trap = 1'b1;
          state_d  = ST_HALT;
        end
      end
      ST_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = (cls.addu || cls.subu) ? REGDST_RD : REGDST_RT;
        ctl.mem_to_reg = cls.lw ? M2R_MEM : M2R_ALU;
        state_d        = ST_FETCH;
      end
      ST_BRANCH: begin
        ctl.alu_op   = ALU_SUB;
        ctl.alu_src  = 1'b0;
        ctl.pc_write = zero;
        ctl.pc_src   = PCSRC_BR;
        state_d      = ST_FETCH;
      end
      ST_HALT: ctl.trap = 1'b1;
      default: begin
        ctl.trap = 1'b1;
        state_d  = ST_HALT;
      end
    endcase
  end

  // Wait counter: cleared on entry to a waiting state, counts idle cycles
  always_comb begin
    tmo_d = tmo_q;
    if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM)))
      tmo_d = '0;
    else if (waiting && !mem_ready && !timed_out)
      tmo_d = tmo_q + 8'd1;
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt_q, instr_cnt_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FETCH;
      tmo_q       <= '0;
`ifdef MC_CTRL_PERF_EN
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
`ifdef MC_CTRL_PERF_EN
      if (state_q != ST_HALT)
        cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if ((state_d == ST_FETCH) && (state_q != ST_FETCH))
        instr_cnt_q <= instr_cnt_q + 32'd1;
`endif
    end
  end

`ifdef MC_CTRL_PERF_EN
  assign cyc_cnt   = cyc_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

  assign ctl_o = reset ? ctl : '0;

  assign mem_req    = ctl_o.mem_req;
  assign mem_we     = ctl_o.mem_we;
  assign ir_write   = ctl_o.ir_write;
  assign pc_write   = ctl_o.pc_write;
  assign pc_src     = ctl_o.pc_src;
  assign alu_op     = ctl_o.alu_op;
  assign alu_src    = ctl_o.alu_src;
  assign ext_op     = ctl_o.ext_op;
  assign reg_write  = ctl_o.reg_write;
  assign reg_dst    = ctl_o.reg_dst;
  assign mem_to_reg = ctl_o.mem_to_reg;
  assign trap       = ctl_o.trap;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm -- scoreboard bench for mc_ctrl_fsm.
// The driver walks each instruction through its architectural phases
// (fetch with N wait cycles, decode, execute, memory, write-back) and
// pushes the control word the instruction should produce each cycle.
// A negedge monitor pops and compares. Build with MC_CTRL_PERF_EN to
// also check the perf counters.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_write, pc_write, alu_src, ext_op, reg_write, trap;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src(alu_src), .ext_op(ext_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .trap(trap)
`ifdef MC_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );

  typedef struct packed {
    logic       mem_req, mem_we, ir_write, pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src, ext_op, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       trap;
  } word_t;

  typedef struct {
    word_t e;
    word_t m;
    string tag;
  } item_t;

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                    K_J, K_JAL, K_JR, K_NOP, K_ILL} kind_e;

  item_t q[$];
  int    vecs = 0;
  int    miss = 0;
  int    done_instr = 0;

  function automatic word_t actual();
    return {mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, alu_src,
            ext_op, reg_write, reg_dst, mem_to_reg, trap};
  endfunction

  // monitor: one expected word per cycle, compared away from the edge
  always @(negedge clk) begin
    item_t it;
    word_t a;
    if (q.size() > 0) begin
      it = q.pop_front();
      a = actual();
      vecs++;
      if ((a & it.m) !== (it.e & it.m)) begin
        miss++;
        $display("FAIL %s: got %h expected %h (t=%0t)", it.tag, a, it.e, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input word_t e, input word_t m, input string tag,
                     input logic rdy, input logic [5:0] o, input logic [5:0] f,
                     input logic z);
    item_t it;
    op = o; funct = f; mem_ready = rdy; zero = z;
    it.e = e; it.m = m; it.tag = tag;
    q.push_back(it);
    @(posedge clk); #1;
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  task automatic enc(input kind_e k, output logic [5:0] o, output logic [5:0] f);
    f = r6();
    case (k)
      K_ADDU: begin o = 6'h00; f = 6'h21; end
      K_SUBU: begin o = 6'h00; f = 6'h23; end
      K_ORI:  o = 6'h0d;
      K_LUI:  o = 6'h0f;
      K_LW:   o = 6'h23;
      K_SW:   o = 6'h2b;
      K_BEQ:  o = 6'h04;
      K_J:    o = 6'h02;
      K_JAL:  o = 6'h03;
      K_JR:   begin o = 6'h00; f = 6'h08; end
      K_NOP:  begin o = 6'h00; f = 6'h00; end
      default: o = 6'h3f;
    endcase
  endtask

  task automatic do_reset();
    word_t z0;
    z0 = '0;
    reset = 1'b0;
    cyc(z0, '1, "reset_state", rb(), r6(), r6(), rb());
    cyc(z0, '1, "reset_state", rb(), r6(), r6(), rb());
    reset = 1'b1;
`ifdef MC_CTRL_PERF_EN
    chk("perf_cyc_reset", cyc_cnt, 0);
    chk("perf_instr_reset", instr_cnt, 0);
`endif
    done_instr = 0;
  endtask

  task automatic halt_cycles(input int n);
    word_t e;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] c0, i0;
    c0 = cyc_cnt; i0 = instr_cnt;
    chk("perf_instr_at_trap", instr_cnt, done_instr);
`endif
    e = '0; e.trap = 1'b1;
    repeat (n) cyc(e, '1, "halt", rb(), r6(), r6(), rb());
`ifdef MC_CTRL_PERF_EN
    chk("perf_cyc_frozen", cyc_cnt, c0);
    chk("perf_instr_frozen", instr_cnt, i0);
`endif
  endtask

  // One instruction from fetch to return to FETCH.
  // wf/wm: cycles without mem_ready before it arrives in fetch / mem.
  // rst_mem: assert reset part-way through the first MEM cycle instead.
  task automatic do_instr(input kind_e k, input int wf, input int wm,
                          input logic z, input bit rst_mem);
    word_t e, m;
    logic [5:0] o, f;
    bit rtype, memop;
    enc(k, o, f);
    rtype = (k == K_ADDU) || (k == K_SUBU);
    memop = (k == K_LW) || (k == K_SW);
    for (int i = 0; i <= wf; i++) begin
      e = '0; e.mem_req = 1'b1;
      if (i == wf) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      cyc(e, '1, "fetch", (i == wf), r6(), r6(), rb());
    end
    e = '0;
    case (k)
      K_J:   begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
      K_JAL: begin e.pc_write = 1'b1; e.pc_src = 2'd2; e.reg_write = 1'b1;
                   e.reg_dst = 2'd2; e.mem_to_reg = 2'd2; end
      K_JR:  begin e.pc_write = 1'b1; e.pc_src = 2'd3; end
      K_ILL: e.trap = 1'b1;
      default: ;
    endcase
    cyc(e, '1, "decode", rb(), o, f, rb());
    if (k == K_ILL) begin
      halt_cycles(6);
      return;
    end
    if (k inside {K_J, K_JAL, K_JR, K_NOP}) begin
      done_instr++;
      return;
    end
    if (k == K_BEQ) begin
      e = '0; e.alu_op = 3'd1; e.pc_src = 2'd1; e.pc_write = z;
      cyc(e, '1, "branch", rb(), o, f, z);
      done_instr++;
      return;
    end
    e = '0; m = '1;
    case (k)
      K_SUBU: e.alu_op = 3'd1;
      K_ORI:  begin e.alu_op = 3'd2; e.alu_src = 1'b1; end
      K_LUI:  begin e.alu_op = 3'd3; e.alu_src = 1'b1; end
      K_LW, K_SW: begin e.alu_src = 1'b1; e.ext_op = 1'b1; end
      default: ;
    endcase
    if (rtype) m.ext_op = 1'b0;
    cyc(e, m, "exec", rb(), o, f, rb());
    if (memop) begin
      if (rst_mem) begin
        op = o; funct = f; mem_ready = 1'b0;
        #2;
        chk("rst_mem_req_before", {30'd0, mem_req, mem_we}, {30'd0, 1'b1, k == K_SW});
        reset = 1'b0;
        #1;
        chk("rst_mem_req_async", {30'd0, mem_req, mem_we}, 32'd0);
        @(posedge clk); #1;
        e = '0;
        cyc(e, '1, "reset_state", rb(), r6(), r6(), rb());
        reset = 1'b1;
        done_instr = 0;
        return;
      end
      for (int i = 0; i <= wm; i++) begin
        e = '0; e.mem_req = 1'b1; e.mem_we = (k == K_SW);
        cyc(e, '1, "mem", (i == wm), o, f, rb());
      end
      if (k == K_SW) begin
        done_instr++;
        return;
      end
    end
    e = '0; e.reg_write = 1'b1;
    e.reg_dst = rtype ? 2'd1 : 2'd0;
    e.mem_to_reg = (k == K_LW) ? 2'd1 : 2'd0;
    cyc(e, '1, "wb", rb(), o, f, rb());
    done_instr++;
  endtask

  task automatic fetch_timeout();
    word_t e;
    e = '0; e.mem_req = 1'b1;
    for (int i = 0; i < 255; i++) cyc(e, '1, "tmo_wait", 1'b0, r6(), r6(), rb());
    e.trap = 1'b1;
    cyc(e, '1, "tmo_trap", 1'b0, r6(), r6(), rb());
    halt_cycles(6);
  endtask

  initial begin
    reset = 1'b0;
    #3;
    @(posedge clk); #1;
    do_reset();
    do_instr(K_ADDU, 0, 0, 1'b0, 1'b0);
    do_instr(K_LW,   0, 3, 1'b0, 1'b0);
    do_instr(K_BEQ,  0, 0, 1'b1, 1'b0);
    do_instr(K_BEQ,  0, 0, 1'b0, 1'b0);
    do_instr(K_JAL,  0, 0, 1'b0, 1'b0);
    do_instr(K_SW,   1, 0, 1'b0, 1'b1);
    do_instr(K_SW,   0, 2, 1'b0, 1'b0);
    for (int n = 0; n < 300; n++)
      do_instr(kind_e'($urandom_range(0, 10)), $urandom_range(0, 3),
               $urandom_range(0, 3), rb(), 1'b0);
    // ready exactly on the timeout-limit cycle must still complete the fetch
    do_instr(K_NOP,  255, 0, 1'b0, 1'b0);
    do_instr(K_LW,   2, 255, 1'b0, 1'b0);
    do_instr(K_ILL,  0, 0, 1'b0, 1'b0);
    do_reset();
    do_instr(K_ORI, 1, 0, 1'b0, 1'b0);
    // unsupported R-type funct (add, 0x20) is also illegal
    begin
      word_t e;
      e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
      cyc(e, '1, "fetch", 1'b1, r6(), r6(), rb());
      e = '0; e.trap = 1'b1;
      cyc(e, '1, "decode_ill_funct", rb(), 6'h00, 6'h20, rb());
      halt_cycles(4);
    end
    do_reset();
    fetch_timeout();
    do_reset();
    do_instr(K_LUI, 0, 0, 1'b0, 1'b0);
    do_instr(K_SUBU, 2, 0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss + 1);
    $fatal(1);
  end

endmodule
